// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling FSM, FWFT byte FIFO.
// Sticky overrun/framing flags, active-low ready, one-cycle pop.
module uart_rx_fifo #(
  parameter int FREQ       = 27_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rxrdy_n,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          frame_err,
  input  logic          clr_err
);

  localparam int DIV = (FREQ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [AW:0]   CAP  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_e;

  state_e        state_q, state_d;
  logic          s1_q, s2_q;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovr_q, ovr_d;
  logic          fe_q, fe_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic rx_s, tick, push, fe_set;
  logic empty, full, do_pop, do_push, ovr_set;

  assign rx_s = s2_q;
  assign tick = (baud_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= rx;
      s2_q    <= s1_q;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= shift_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: if (tick) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (tick && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (tick) state_d = rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    baud_d  = tick ? baud_q : baud_q - CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    unique case (state_q)
      S_IDLE: if (!rx_s) baud_d = HALF;
      S_START: begin
        if (tick && !rx_s) begin
          baud_d = FULL;
          bit_d  = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d[bit_q] = rx_s;
          baud_d         = FULL;
          bit_d          = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          push   = rx_s;
          fe_set = !rx_s;
        end
      end
      default: ;
    endcase
  end

  // A pop frees the slot a simultaneous push needs, so full+pop never overruns.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CAP);
    do_pop  = rd_en & !empty;
    do_push = push & (!full | do_pop);
    ovr_set = push & full & !do_pop;
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    ovr_d   = (ovr_q & ~clr_err) | ovr_set;
    fe_d    = (fe_q & ~clr_err) | fe_set;
  end

  assign rxrdy_n   = empty;
  assign rd_data   = empty ? 8'h00 : mem_q[rptr_q];
  assign count     = count_q;
  assign overrun   = ovr_q;
  assign frame_err = fe_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table of single frames plus hand-written
// overrun, glitch, simultaneous push/pop and reset sequences.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst, rx, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       rxrdy_n;
  logic [4:0] count;
  logic       overrun, frame_err;

  uart_rx_fifo #(.FREQ(16), .BAUD(1), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en),
    .rd_data(rd_data), .rxrdy_n(rxrdy_n), .count(count),
    .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    logic [4:0] exp_count;
    logic       exp_fe;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Push at posedge 155 of the frame lands in iteration 154.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int pop_cyc);
    int k;
    if (stop_ok) begin
      if (q.size() < 16 || pop_cyc >= 0) q.push_back(b);
    end
    for (int c = 0; c < 160; c++) begin
      k = c / 16;
      if (k == 0) rx = 1'b0;
      else if (k <= 8) rx = b[k-1];
      else rx = stop_ok;
      rd_en = (c == pop_cyc);
      if (c == pop_cyc) begin
        chk("simul_pop_data", {24'd0, rd_data}, {24'd0, q[0]});
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  task automatic pop_chk(input string name);
    logic [7:0] e;
    if (q.size() != 0) e = q.pop_front();
    else e = 8'h00;
    chk({name, "_rdy"}, {31'd0, rxrdy_n}, 32'd0);
    chk({name, "_data"}, {24'd0, rd_data}, {24'd0, e});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 5'd1, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 5'd0, 1'b1};
    tbl[2] = '{8'h3C, 1'b1, 5'd1, 1'b0};
    tbl[3] = '{8'h00, 1'b1, 5'd1, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 5'd1, 1'b0};
    tbl[5] = '{8'h5A, 1'b1, 5'd1, 1'b0};

    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_rdy", {31'd0, rxrdy_n}, 32'd1);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_data", {24'd0, rd_data}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_fe", {31'd0, frame_err}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].stop_ok, -1);
      if (!tbl[i].stop_ok) begin
        rx = 1'b0;
        idle(40);
        rx = 1'b1;
      end
      idle(4);
      chk("tbl_count", {27'd0, count}, {27'd0, tbl[i].exp_count});
      chk("tbl_rdy", {31'd0, rxrdy_n}, {31'd0, tbl[i].exp_count == 0});
      chk("tbl_fe", {31'd0, frame_err}, {31'd0, tbl[i].exp_fe});
      if (tbl[i].exp_count != 0) begin
        pop_chk("tbl_pop");
        chk("tbl_rdy_after", {31'd0, rxrdy_n}, 32'd1);
        chk("tbl_data_after", {24'd0, rd_data}, 32'd0);
      end
      if (tbl[i].exp_fe) begin
        pulse_clr();
        chk("tbl_fe_clr", {31'd0, frame_err}, 32'd0);
      end
    end

    // Overrun: 17 frames with no reads.
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, -1);
    idle(2);
    chk("ovr_count", {27'd0, count}, 32'd16);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 16; i++) pop_chk("ovr_pop");
    chk("ovr_empty", {31'd0, rxrdy_n}, 32'd1);
    pulse_clr();
    chk("ovr_clr", {31'd0, overrun}, 32'd0);

    // Glitch shorter than half a bit.
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(40);
    chk("glitch_count", {27'd0, count}, 32'd0);
    chk("glitch_fe", {31'd0, frame_err}, 32'd0);
    chk("glitch_ovr", {31'd0, overrun}, 32'd0);
    send_frame(8'hC3, 1'b1, -1);
    idle(2);
    pop_chk("glitch_next");

    // Full FIFO with a pop on the push edge of the 17th byte.
    for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b1, -1);
    send_frame(8'hEE, 1'b1, 154);
    idle(2);
    chk("simul_count", {27'd0, count}, 32'd16);
    chk("simul_ovr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 16; i++) pop_chk("simul_drain");
    chk("simul_empty", {27'd0, count}, 32'd0);
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
    chk("empty_pop_count", {27'd0, count}, 32'd0);
    chk("empty_pop_rdy", {31'd0, rxrdy_n}, 32'd1);
    chk("empty_pop_data", {24'd0, rd_data}, 32'd0);

    // Reset in the middle of a frame, with a byte already buffered.
    send_frame(8'h5A, 1'b1, -1);
    rx = 1'b0;
    idle(16);
    rx = 1'b1;
    idle(40);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    q.delete();
    idle(1);
    chk("mid_rst_count", {27'd0, count}, 32'd0);
    chk("mid_rst_rdy", {31'd0, rxrdy_n}, 32'd1);
    chk("mid_rst_data", {24'd0, rd_data}, 32'd0);
    chk("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    chk("mid_rst_fe", {31'd0, frame_err}, 32'd0);
    idle(200);
    chk("mid_rst_idle", {27'd0, count}, 32'd0);
    send_frame(8'h81, 1'b1, -1);
    idle(2);
    chk("after_rst_count", {27'd0, count}, 32'd1);
    pop_chk("after_rst_pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
